// File: rtl/regfile_sb.sv
// regfile_sb -- integer register file with an integrated issue scoreboard.
//
// Sits between decode/issue (read + reserve) and writeback (write). Each
// register carries a busy bit that is set when an instruction reserves it
// as its destination and cleared when the result is written back. Register
// x0 reads as zero, ignores writes and is never busy.
//
// Parameters:
//   XLEN   data width
//   NREGS  number of architectural registers (power of 2, >= 2)
//   NRD    number of combinational read ports (1..4)
//
// Ports:
//   clk        clock, rising edge
//   reset      synchronous, active-high; overrides every other input
//   rs_addr    read addresses, port i = [i*AW +: AW]
//   rs_data    read data, port i = [i*XLEN +: XLEN]
//   rs_busy    busy bit of the register on each read port
//   rsv_valid  reserve request for rsv_rd
//   rsv_rd     destination register to reserve
//   rsv_ready  reservation accepted this cycle (combinational)
//   we/wa/wd   writeback enable, address, data
//   flush      clears every busy bit; register contents are kept
//   busy_cnt   registered count of busy registers
//   err_unrsv  sticky: a write hit a non-busy register other than x0
//
// Build option:
//   RF_BYPASS_EN  when defined, a same-cycle write to a read address is
//                 forwarded to that read port (data = wd, busy = 0).
//                 When undefined, read ports show the stored state until
//                 the edge. rsv_ready is the same either way.

module regfile_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NRD*$clog2(NREGS)-1:0]  rs_addr,
    output logic [NRD*XLEN-1:0]           rs_data,
    output logic [NRD-1:0]                rs_busy,
    input  logic                          rsv_valid,
    input  logic [$clog2(NREGS)-1:0]      rsv_rd,
    output logic                          rsv_ready,
    input  logic                          we,
    input  logic [$clog2(NREGS)-1:0]      wa,
    input  logic [XLEN-1:0]               wd,
    input  logic                          flush,
    output logic [$clog2(NREGS):0]        busy_cnt,
    output logic                          err_unrsv
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic [AW:0]      cnt_nxt;
    logic             wr_en;

    assign wr_en = we && (wa != '0);

    // A busy destination stalls the reservation (WAW), unless it is being
    // written back in this very cycle: the new owner then takes over.
    assign rsv_ready = rsv_valid && !flush &&
                       ((rsv_rd == '0) || !busy[rsv_rd] || (we && (wa == rsv_rd)));

    // Clear-on-write is applied before set-on-reserve so that a same-cycle
    // write and reserve of one register leaves it busy.
    always_comb begin
        busy_nxt = busy;
        if (flush) begin
            busy_nxt = '0;
        end else begin
            if (wr_en)
                busy_nxt[wa] = 1'b0;
            if (rsv_ready && (rsv_rd != '0))
                busy_nxt[rsv_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < NREGS; i++)
            cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[i]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (wr_en) begin
            regs[wa] <= wd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy      <= '0;
            busy_cnt  <= '0;
            err_unrsv <= 1'b0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
            if (wr_en && !busy[wa])
                err_unrsv <= 1'b1;
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0] ra;
        assign ra = rs_addr[g*AW +: AW];
`ifdef RF_BYPASS_EN
        logic hit;
        assign hit = wr_en && (wa == ra);
        assign rs_data[g*XLEN +: XLEN] = (ra == '0) ? '0 : (hit ? wd : regs[ra]);
        assign rs_busy[g] = (ra != '0) && !hit && busy[ra];
`else
        assign rs_data[g*XLEN +: XLEN] = (ra == '0) ? '0 : regs[ra];
        assign rs_busy[g] = (ra != '0) && busy[ra];
`endif
    end

endmodule
